// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction loader.
// The CHECK state is only reached when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

    localparam int BYTE_IDX_W = 2;
    localparam logic [31:0] END_WORD_DEF = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        FLUSH,
        DONE,
        ERROR,
        CHECK
    } loaderState_t;

endpackage

// File: rtl/loader_word_assembler.sv
// Packs an MSB-first byte stream into 32-bit words.
// The finished word is held in its own register so the next byte can shift in during the write cycle.
module loader_word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byteValid,
    input  logic [7:0]  byteIn,
    output logic [31:0] word,
    output logic        wordValid
);

    logic [23:0]           shiftReg;
    logic [BYTE_IDX_W-1:0] byteIdx;

    // Shift bytes in; on the fourth byte latch the word and strobe for one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shiftReg  <= '0;
            byteIdx   <= '0;
            word      <= '0;
            wordValid <= 1'b0;
        end else begin
            wordValid <= 1'b0;
            if (clear) begin
                shiftReg <= '0;
                byteIdx  <= '0;
                word     <= '0;
            end else if (byteValid) begin
                shiftReg <= {shiftReg[15:0], byteIn};
                byteIdx  <= byteIdx + BYTE_IDX_W'(1);
                if (byteIdx == '1) begin
                    word      <= {shiftReg, byteIn};
                    wordValid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Loads a program from the debug UART byte stream into instruction memory.
// Optional LOADER_CHECKSUM_EN adds a trailing XOR checksum byte after the terminator word.
module instruction_loader
    import loader_pkg::*;
#(
    parameter int          MAX_WORDS      = 1024,
    parameter int          ADDR_W         = 10,
    parameter logic [31:0] END_WORD       = END_WORD_DEF,
    parameter int          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inStart,
    input  logic [7:0]        inRxData,
    input  logic              inRxValid,
    output logic              outWrInstruction,
    output logic [31:0]       outDataInstruction,
    output logic [ADDR_W-1:0] outWrAddr,
    output logic              outStopPC,
    output logic              outCoreRst,
    output logic              outDone,
    output logic              outError,
    output logic [ADDR_W:0]   outWordCount
);

    loaderState_t    state;
    loaderState_t    nextState;
    logic [ADDR_W:0] wordCount;
    logic [31:0]     idleCnt;
    logic            startLoad;
    logic            asmClear;
    logic            byteValid;
    logic [31:0]     asmWord;
    logic            asmValid;
    logic            endHit;
    logic            lastSlot;
    logic            timedOut;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]      csum;
`endif

    assign byteValid = (state == RECV) && inRxValid;
    assign asmClear  = (state != RECV);
    assign endHit    = asmValid && (asmWord == END_WORD);
    assign lastSlot  = (wordCount == (ADDR_W+1)'(MAX_WORDS - 1));
    assign timedOut  = !inRxValid && (idleCnt == 32'(TIMEOUT_CYCLES - 1));

    loader_word_assembler uAsm (
        .clk       (clk),
        .rst       (rst),
        .clear     (asmClear),
        .byteValid (byteValid),
        .byteIn    (inRxData),
        .word      (asmWord),
        .wordValid (asmValid)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    // Next-state decode; a terminator write takes priority over the overflow check
    always_comb begin
        nextState = state;
        startLoad = 1'b0;
        unique case (state)
            IDLE, DONE, ERROR: begin
                if (inStart) begin
                    nextState = RECV;
                    startLoad = 1'b1;
                end
            end
            RECV: begin
                if (endHit) begin
`ifdef LOADER_CHECKSUM_EN
                    if (inRxValid)
                        nextState = (inRxData == csum) ? FLUSH : ERROR;
                    else
                        nextState = CHECK;
`else
                    nextState = FLUSH;
`endif
                end else if (asmValid && lastSlot) begin
                    nextState = ERROR;
                end else if (timedOut) begin
                    nextState = ERROR;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (inRxValid)
                    nextState = (inRxData == csum) ? FLUSH : ERROR;
                else if (timedOut)
                    nextState = ERROR;
            end
`endif
            FLUSH:   nextState = DONE;
            default: nextState = IDLE;
        endcase
    end

    // Word count and inter-byte idle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wordCount <= '0;
            idleCnt   <= '0;
        end else if (startLoad) begin
            wordCount <= '0;
            idleCnt   <= '0;
        end else if (state == RECV || state == CHECK) begin
            idleCnt <= inRxValid ? 32'd0 : idleCnt + 32'd1;
            if (state == RECV && asmValid)
                wordCount <= wordCount + (ADDR_W+1)'(1);
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR of every byte accepted while receiving
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            csum <= '0;
        else if (startLoad)
            csum <= '0;
        else if (byteValid)
            csum <= csum ^ inRxData;
    end
`endif

    assign outWrInstruction   = asmValid && (state == RECV);
    assign outDataInstruction = asmWord;
    assign outWrAddr          = wordCount[ADDR_W-1:0];
    assign outWordCount       = wordCount;
    assign outStopPC          = (state != DONE);
    assign outCoreRst         = (state == FLUSH);
    assign outDone            = (state == DONE);
    assign outError           = (state == ERROR);

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader with small MAX_WORDS and TIMEOUT_CYCLES.
// Sends the checksum byte when LOADER_CHECKSUM_EN is defined.
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inStart = 1'b0;
    logic [7:0]  inRxData = 8'd0;
    logic        inRxValid = 1'b0;
    logic        outWrInstruction;
    logic [31:0] outDataInstruction;
    logic [1:0]  outWrAddr;
    logic        outStopPC;
    logic        outCoreRst;
    logic        outDone;
    logic        outError;
    logic [2:0]  outWordCount;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] wrData[$];
    logic [1:0]  wrAddr[$];
    int          rstPulses = 0;
    logic [7:0]  tbCsum = 8'd0;

    instruction_loader #(
        .MAX_WORDS      (4),
        .ADDR_W         (2),
        .END_WORD       (32'hFFFF_FFFF),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .inStart            (inStart),
        .inRxData           (inRxData),
        .inRxValid          (inRxValid),
        .outWrInstruction   (outWrInstruction),
        .outDataInstruction (outDataInstruction),
        .outWrAddr          (outWrAddr),
        .outStopPC          (outStopPC),
        .outCoreRst         (outCoreRst),
        .outDone            (outDone),
        .outError           (outError),
        .outWordCount       (outWordCount)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (outWrInstruction === 1'b1) begin
            wrData.push_back(outDataInstruction);
            wrAddr.push_back(outWrAddr);
        end
        if (outCoreRst === 1'b1) rstPulses++;
    end

    task automatic clearLog();
        wrData.delete();
        wrAddr.delete();
        rstPulses = 0;
    endtask

    task automatic doReset();
        rst = 1'b0;
        inStart = 1'b0;
        inRxValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        clearLog();
    endtask

    task automatic startLoad();
        inStart = 1'b1;
        @(negedge clk);
        inStart = 1'b0;
        tbCsum = 8'd0;
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        inRxData = b;
        inRxValid = 1'b1;
        tbCsum = tbCsum ^ b;
        @(negedge clk);
        inRxValid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic sendWord(input logic [31:0] w, input int gap);
        sendByte(w[31:24], gap);
        sendByte(w[23:16], gap);
        sendByte(w[15:8], gap);
        sendByte(w[7:0], gap);
    endtask

    task automatic finishLoad(input int gap);
        sendWord(32'hFFFF_FFFF, gap);
`ifdef LOADER_CHECKSUM_EN
        sendByte(tbCsum, gap);
`endif
    endtask

    task automatic waitEnd(input int bound);
        for (int i = 0; i < bound && !outDone && !outError; i++)
            @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [41:0] obs;
        rst = 1'b0;
        #1;
        obs = {outStopPC, outDone, outError, outCoreRst, outWrInstruction,
               outWordCount, outWrAddr, outDataInstruction};
        vectors++;
        if (obs !== {1'b1, 41'd0}) begin
            miscompares++;
            $display("FAIL reset_vals got %h want %h", obs, {1'b1, 41'd0});
        end
        @(negedge clk);
        rst = 1'b1;
        clearLog();
        repeat (100) @(negedge clk);
        vectors++;
        if (wrData.size() !== 0) begin
            miscompares++;
            $display("FAIL idle_writes got %0d want 0", wrData.size());
        end
        vectors++;
        if ({outStopPC, outDone, outError} !== 3'b100) begin
            miscompares++;
            $display("FAIL idle_flags got %b want 100", {outStopPC, outDone, outError});
        end
    endtask

    task automatic test_normal_load();
        logic [31:0] expD [3];
        expD = '{32'h2001_0005, 32'h0000_0000, 32'hFFFF_FFFF};
        doReset();
        startLoad();
        sendWord(32'h2001_0005, 1);
        sendWord(32'h0000_0000, 1);
        finishLoad(1);
        waitEnd(20);
        vectors++;
        if (wrData.size() !== 3) begin
            miscompares++;
            $display("FAIL normal_nwrites got %0d want 3", wrData.size());
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (wrData[i] !== expD[i] || wrAddr[i] !== 2'(i)) begin
                miscompares++;
                $display("FAIL normal_wr%0d got %h@%0d want %h@%0d",
                         i, wrData[i], wrAddr[i], expD[i], i);
            end
        end
        vectors++;
        if (rstPulses !== 1) begin
            miscompares++;
            $display("FAIL normal_corerst got %0d cycles want 1", rstPulses);
        end
        vectors++;
        if ({outDone, outStopPC, outError, outWordCount} !== {3'b100, 3'd3}) begin
            miscompares++;
            $display("FAIL normal_done got %b want 100011",
                     {outDone, outStopPC, outError, outWordCount});
        end
        startLoad();
        vectors++;
        if ({outDone, outStopPC} !== 2'b01) begin
            miscompares++;
            $display("FAIL restart_flags got %b want 01", {outDone, outStopPC});
        end
    endtask

    task automatic test_back_to_back();
        doReset();
        startLoad();
        sendWord(32'h1122_3344, 0);
        sendWord(32'h5566_7788, 0);
        finishLoad(0);
        waitEnd(20);
        vectors++;
        if (wrData.size() !== 3) begin
            miscompares++;
            $display("FAIL b2b_nwrites got %0d want 3", wrData.size());
        end
        vectors++;
        if (wrData[0] !== 32'h1122_3344 || wrAddr[0] !== 2'd0) begin
            miscompares++;
            $display("FAIL b2b_wr0 got %h@%0d want 11223344@0", wrData[0], wrAddr[0]);
        end
        vectors++;
        if (wrData[1] !== 32'h5566_7788 || wrAddr[1] !== 2'd1) begin
            miscompares++;
            $display("FAIL b2b_wr1 got %h@%0d want 55667788@1", wrData[1], wrAddr[1]);
        end
        vectors++;
        if ({outDone, rstPulses[1:0], outWordCount} !== {1'b1, 2'd1, 3'd3}) begin
            miscompares++;
            $display("FAIL b2b_done got done=%b pulses=%0d cnt=%0d want 1 1 3",
                     outDone, rstPulses, outWordCount);
        end
    endtask

    task automatic test_timeout();
        doReset();
        startLoad();
        sendByte(8'hAB, 0);
        sendByte(8'hCD, 0);
        repeat (99) @(negedge clk);
        vectors++;
        if (outError !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_early got %b want 0", outError);
        end
        @(negedge clk);
        vectors++;
        if ({outError, outStopPC} !== 2'b11) begin
            miscompares++;
            $display("FAIL timeout_err got %b want 11", {outError, outStopPC});
        end
        vectors++;
        if (wrData.size() !== 0) begin
            miscompares++;
            $display("FAIL timeout_writes got %0d want 0", wrData.size());
        end
        startLoad();
        vectors++;
        if (outError !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_clear got %b want 0", outError);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] expD [4];
        expD = '{32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 32'h0D0E_0F10};
        doReset();
        startLoad();
        for (int i = 0; i < 4; i++) sendWord(expD[i], 0);
        waitEnd(20);
        vectors++;
        if (wrData.size() !== 4) begin
            miscompares++;
            $display("FAIL ovf_nwrites got %0d want 4", wrData.size());
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (wrData[i] !== expD[i] || wrAddr[i] !== 2'(i)) begin
                miscompares++;
                $display("FAIL ovf_wr%0d got %h@%0d want %h@%0d",
                         i, wrData[i], wrAddr[i], expD[i], i);
            end
        end
        vectors++;
        if ({outError, outDone, outWordCount} !== {2'b10, 3'd4} || rstPulses !== 0) begin
            miscompares++;
            $display("FAIL ovf_state got err=%b done=%b cnt=%0d pulses=%0d want 1 0 4 0",
                     outError, outDone, outWordCount, rstPulses);
        end
    endtask

    task automatic test_async_reset();
        logic [41:0] obs;
        doReset();
        startLoad();
        sendWord(32'h0BAD_F00D, 0);
        sendByte(8'h12, 0);
        sendByte(8'h34, 0);
        vectors++;
        if (outWordCount !== 3'd1) begin
            miscompares++;
            $display("FAIL mid_count got %0d want 1", outWordCount);
        end
        rst = 1'b0;
        #1;
        obs = {outStopPC, outDone, outError, outCoreRst, outWrInstruction,
               outWordCount, outWrAddr, outDataInstruction};
        vectors++;
        if (obs !== {1'b1, 41'd0}) begin
            miscompares++;
            $display("FAIL async_vals got %h want %h", obs, {1'b1, 41'd0});
        end
        @(negedge clk);
        rst = 1'b1;
        clearLog();
        startLoad();
        sendWord(32'hA1B2_C3D4, 1);
        finishLoad(1);
        waitEnd(20);
        vectors++;
        if (wrData.size() !== 2 || wrData[0] !== 32'hA1B2_C3D4 || wrAddr[0] !== 2'd0) begin
            miscompares++;
            $display("FAIL async_reload got n=%0d %h@%0d want n=2 a1b2c3d4@0",
                     wrData.size(), wrData[0], wrAddr[0]);
        end
        vectors++;
        if ({outDone, outWordCount} !== {1'b1, 3'd2}) begin
            miscompares++;
            $display("FAIL async_done got %b want 1010", {outDone, outWordCount});
        end
    endtask

    initial begin
        test_reset();
        test_normal_load();
        test_back_to_back();
        test_timeout();
        test_overflow();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Upstream companion to the fetch stage. Receives a byte stream from the debug UART receiver, assembles 32-bit instructions, and drives the instruction-memory write port (`wr_instruction`, `data_instruction`).
- Holds the PC frozen through `stopPC_debug` while a program is loaded. Releases the core with a one-cycle core-reset pulse once a complete program has been received.

Parameters:
- MAX_WORDS, 1024: instruction-memory depth in words; load aborts if exceeded.
- ADDR_W, 10: width of the word address/count outputs; must satisfy 2**ADDR_W >= MAX_WORDS.
- END_WORD, 32'hFFFF_FFFF: terminator instruction; it is written to memory, then the load completes.
- TIMEOUT_CYCLES, 1_000_000: maximum idle clocks between bytes while receiving before the load aborts.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- inStart  in  1  single-cycle request to begin a new load.
- inRxData  in  8  received UART byte.
- inRxValid  in  1  one-cycle strobe qualifying inRxData.
- outWrInstruction  out  1  memory write strobe, one cycle per word.
- outDataInstruction  out  32  assembled instruction word.
- outWrAddr  out  ADDR_W  word address of the current write (0-based).
- outStopPC  out  1  PC freeze request, drives stopPC_debug.
- outCoreRst  out  1  one-cycle active-high pulse that resets the pipeline after a successful load.
- outDone  out  1  load completed successfully; level output.
- outError  out  1  load aborted; level output.
- outWordCount  out  ADDR_W+1  number of words written in the current or last load.

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE.
  - outStopPC=1: no valid program exists, so the core stays frozen.
  - All other outputs 0; byte index 0; timeout counter 0.
- States: IDLE, RECV, FLUSH, DONE, ERROR.
- IDLE:
  - inStart=1 -> RECV next cycle; clear word count, byte index and timeout counter.
  - inRxValid in IDLE, including the same cycle as inStart, is ignored.
- RECV:
  - Each inRxValid shifts the byte in MSB-first: the first byte of a word goes to bits [31:24], the fourth to bits [7:0].
  - On the 4th byte, the cycle after acceptance shows: outWrInstruction=1, outDataInstruction=word, outWrAddr=word count.
  - The word count increments in that same write cycle.
  - The write is registered, so a byte arriving during the write cycle is accepted as byte 0 of the next word; no byte is ever lost.
  - Written word == END_WORD -> FLUSH after its write cycle.
  - Word count reaching MAX_WORDS without END_WORD -> ERROR; that word is still written.
  - Timeout counter clears on every inRxValid and increments otherwise. Reaching TIMEOUT_CYCLES -> ERROR; any partial word is discarded.
  - inStart is ignored in RECV.
- FLUSH (exactly one cycle): outCoreRst=1, then -> DONE.
- DONE: outDone=1, outStopPC=0 (core runs). inStart -> RECV, clearing outDone and raising outStopPC on the next edge.
- ERROR: outError=1, outStopPC=1. inStart -> RECV, clearing outError.
- outStopPC=1 in IDLE (after reset), RECV, FLUSH and ERROR; 0 only in DONE.
- outWordCount holds its value after DONE/ERROR until the next inStart.
- Reset mid-load: immediate return to IDLE with the reset values above. Memory contents already written are not cleared.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - After the END_WORD write, the loader waits in an extra state CHECK for one more byte.
  - That byte must equal the XOR of all previously received bytes, END_WORD bytes included.
  - Match -> FLUSH. Mismatch or timeout -> ERROR.
- Undefined: no CHECK state; END_WORD leads directly to FLUSH.

Decomposition:
- Package loader_pkg holds:
  - the state enum (IDLE, RECV, FLUSH, DONE, ERROR, CHECK);
  - the default END_WORD constant;
  - the byte-index width constant (2).
- One sub-module, loader_word_assembler:
  - owns the 32-bit shift register, the 2-bit byte index and the word-complete strobe;
  - clears on a synchronous clear input from the FSM.
- The FSM, counters and timeout stay in instruction_loader.

Test Plan:
- Reset then idle: rst=0 then 1 -> outStopPC=1, outDone=0, outError=0, outWrInstruction never asserted for 100 cycles.
- Normal load:
  - Stimulus: inStart, then bytes 20 01 00 05, 00 00 00 00, FF FF FF FF.
  - Writes: 32'h2001_0005 at addr 0, 0 at addr 1, 32'hFFFF_FFFF at addr 2.
  - Then outCoreRst high for exactly 1 cycle, outDone=1, outStopPC=0, outWordCount=3.
- Back-to-back bytes: inRxValid every cycle for 8 bytes -> two correct writes, no dropped byte; a byte coinciding with a write cycle lands in bits [31:24] of the next word.
- Timeout: TIMEOUT_CYCLES=100, send 2 bytes then silence -> outError=1 at idle cycle 100, no write, outStopPC=1; a later inStart clears outError.
- Overflow: MAX_WORDS=4, send 4 non-END words -> 4 writes (addr 0-3), then outError=1, no outCoreRst.
- Async reset mid-word: drop rst after 2 bytes -> all outputs at reset values immediately, without waiting for a clock edge; after release, a new load starts at addr 0 with byte index 0.
